writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, element/scalar data width.
REQ-002 SHALL have parameter VECTOR_SIZE, default 8, elements per vector.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 4, register address width.
REQ-004 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-005 SHALL have port clock  in  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports exValid in 1 / exReady out 1, the execute-result handshake.
REQ-008 SHALL have ports exIsVector in 1, exAddress in ADDRESS_WIDTH, exScalarData in DATA_WIDTH, exVectorData in VECTOR_SIZE x DATA_WIDTH, the execute result.
REQ-009 SHALL have ports memValid in 1 / memReady out 1, the load-result handshake.
REQ-010 SHALL have ports memIsVector, memAddress, memScalarData and memVectorData, widths as REQ-008, the load result.
REQ-011 SHALL have port stall  in  1  freeze register-file writes.
REQ-012 SHALL have ports queryIsVector in 1, queryAddress1 in ADDRESS_WIDTH, queryAddress2 in ADDRESS_WIDTH, the decode hazard query.
REQ-013 SHALL have ports queryPending1 out 1 and queryPending2 out 1, hazard flags.
REQ-014 SHALL have ports writeEnableScalar out 1, writeEnableVector out 1, writeAddress out ADDRESS_WIDTH, writeScalarData out DATA_WIDTH, writeVectorData out VECTOR_SIZE x DATA_WIDTH, driving the register-file write ports.
REQ-015 SHALL have port count  out  clog2(DEPTH+1)  occupied entries.

Function
REQ-016 SHALL accept one entry per cycle: a transfer occurs when valid && ready on a source.
REQ-017 SHALL assert exReady/memReady only when the queue is not full and that source holds the grant; a full queue SHALL never accept, even if popping in the same cycle.
REQ-018 SHALL arbitrate round-robin when both sources are valid: grant the source not granted last; a lone valid source is granted immediately.
REQ-019 SHALL update the last-grant flag only on an actual transfer.
REQ-020 SHALL present the head entry combinationally on the write ports; the head pops every cycle the queue is non-empty and stall=0.
REQ-021 SHALL drive writeEnableVector=head.isVector and writeEnableScalar=!head.isVector on a pop, and both 0 when empty or stalled.
REQ-022 SHALL write an entry accepted in cycle N no earlier than cycle N+1 (no bypass), in strict acceptance order.
REQ-023 SHALL handle simultaneous push and pop with count unchanged and pointers both advancing; pointers wrap modulo DEPTH.
REQ-024 SHALL assert queryPendingK when any occupied entry, including the head, matches queryAddressK and queryIsVector; the result is combinational from queue state, and the same-cycle incoming entry is excluded.
REQ-025 SHALL hold stall=1 to freeze pops, entries and write enables (0); acceptance continues while not full.

Reset
REQ-026 SHALL, while reset=0 at a rising edge, clear the read/write pointers and count to 0 and set the last-grant flag so that memory wins the first tie.
REQ-027 SHALL, during and after reset until the next edge, hold exReady, memReady, both write enables and both queryPending flags at 0.
REQ-028 SHALL, on reset mid-operation, discard all queued entries with no write issued in the reset cycle.
REQ-029 SHALL leave data storage unreset.

Structure
REQ-030 SHALL define, in shared package wb_pkg, typedef wb_entry_t (isVector, address, scalarData, vectorData) and default-parameter constants.
REQ-031 SHALL contain one sub-module, wb_fifo (DEPTH-entry circular buffer of wb_entry_t with count); arbitration and the hazard comparators stay in the top.

Verification
REQ-032 SHALL cover: single ex scalar write, addr 3, data 0x155 -> next cycle writeEnableScalar=1, writeAddress=3, writeScalarData=0x155, count returns to 0.
REQ-033 SHALL cover: ex and mem both valid for 4 cycles, stall=1 -> grants alternate mem, ex, mem, ex; count=4; both readies 0 in the 5th cycle.
REQ-034 SHALL cover: vector entry addr 5 queued, stall=1, query (isVector=1, addr1=5, addr2=5) -> both pending=1; query isVector=0 -> both pending=0.
REQ-035 SHALL cover: full queue, stall released with ex valid -> one pop, exReady=0 that cycle, exReady=1 the next.
REQ-036 SHALL cover: 3 entries queued, reset=0 for one cycle -> count=0, no write enables, following accepted entry written first.

Source files
------------

// File: rtl/wb_pkg.sv
// Writeback queue shared definitions.
// Default geometry and the queued writeback entry layout.
package wb_pkg;

    localparam int WB_DATA_WIDTH    = 18;
    localparam int WB_VECTOR_SIZE   = 8;
    localparam int WB_ADDRESS_WIDTH = 4;
    localparam int WB_DEPTH         = 4;

    typedef struct packed {
        logic                                     isVector;
        logic [WB_ADDRESS_WIDTH-1:0]              address;
        logic [WB_DATA_WIDTH-1:0]                 scalarData;
        logic [WB_VECTOR_SIZE*WB_DATA_WIDTH-1:0]  vectorData;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries with occupancy count.
// Exposes every slot plus an occupied mask for hazard lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter type T     = wb_entry_t,
    parameter int  DEPTH = WB_DEPTH,
    parameter int  CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  T                 pushData,
    input  logic             pop,
    output T                 head,
    output T                 entries [DEPTH],
    output logic [DEPTH-1:0] occupied,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [PW-1:0]  rdPtr;
    logic [PW-1:0]  wrPtr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clock) begin
        if (push) mem[wrPtr] <= pushData;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_occ
        logic [PW-1:0] offset;
        assign offset      = PW'(i) - rdPtr;
        assign occupied[i] = CW'(offset) < count;
    end

    assign entries = mem;
    assign head    = mem[rdPtr];
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;

endmodule

// File: rtl/writeback_queue.sv
// Two-source writeback queue feeding the register-file write ports.
// Round-robin intake, in-order drain, hazard lookup over queued entries.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int VECTOR_SIZE   = WB_VECTOR_SIZE,
    parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
    parameter int DEPTH         = WB_DEPTH,
    parameter int VW            = VECTOR_SIZE * DATA_WIDTH,
    parameter int CW            = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     exValid,
    output logic                     exReady,
    input  logic                     exIsVector,
    input  logic [ADDRESS_WIDTH-1:0] exAddress,
    input  logic [DATA_WIDTH-1:0]    exScalarData,
    input  logic [VW-1:0]            exVectorData,
    input  logic                     memValid,
    output logic                     memReady,
    input  logic                     memIsVector,
    input  logic [ADDRESS_WIDTH-1:0] memAddress,
    input  logic [DATA_WIDTH-1:0]    memScalarData,
    input  logic [VW-1:0]            memVectorData,
    input  logic                     stall,
    input  logic                     queryIsVector,
    input  logic [ADDRESS_WIDTH-1:0] queryAddress1,
    input  logic [ADDRESS_WIDTH-1:0] queryAddress2,
    output logic                     queryPending1,
    output logic                     queryPending2,
    output logic                     writeEnableScalar,
    output logic                     writeEnableVector,
    output logic [ADDRESS_WIDTH-1:0] writeAddress,
    output logic [DATA_WIDTH-1:0]    writeScalarData,
    output logic [VW-1:0]            writeVectorData,
    output logic [CW-1:0]            count
);

    typedef struct packed {
        logic                     isVector;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]    scalarData;
        logic [VW-1:0]            vectorData;
    } entry_t;

    entry_t           pushData;
    entry_t           head;
    entry_t           entries [DEPTH];
    logic [DEPTH-1:0] occupied;
    logic             full;
    logic             empty;
    logic             lastWasEx;
    logic             grantEx;
    logic             grantMem;
    logic             exFire;
    logic             memFire;
    logic             pop;

    // Reset leaves lastWasEx set so memory wins the first tie.
    always_ff @(posedge clock) begin
        if (!reset)
            lastWasEx <= 1'b1;
        else if (exFire)
            lastWasEx <= 1'b1;
        else if (memFire)
            lastWasEx <= 1'b0;
    end

    assign grantMem = memValid && (!exValid || lastWasEx);
    assign grantEx  = exValid && (!memValid || !lastWasEx);
    assign exReady  = reset && !full && grantEx;
    assign memReady = reset && !full && grantMem;
    assign exFire   = exReady && exValid;
    assign memFire  = memReady && memValid;

    always_comb begin
        pushData = '{exIsVector, exAddress, exScalarData, exVectorData};
        if (memFire)
            pushData = '{memIsVector, memAddress, memScalarData, memVectorData};
    end

    assign pop               = reset && !empty && !stall;
    assign writeEnableVector = pop && head.isVector;
    assign writeEnableScalar = pop && !head.isVector;
    assign writeAddress      = head.address;
    assign writeScalarData   = head.scalarData;
    assign writeVectorData   = head.vectorData;

    always_comb begin
        queryPending1 = 1'b0;
        queryPending2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (reset && occupied[i]
                && entries[i].isVector == queryIsVector) begin
                if (entries[i].address == queryAddress1)
                    queryPending1 = 1'b1;
                if (entries[i].address == queryAddress2)
                    queryPending2 = 1'b1;
            end
        end
    end

    wb_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (exFire || memFire),
        .pushData (pushData),
        .pop      (pop),
        .head     (head),
        .entries  (entries),
        .occupied (occupied),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue.
// Directed scenarios then random traffic against a queue model.
module tb_writeback_queue;

    localparam int DW = 18;
    localparam int VS = 8;
    localparam int AW = 4;
    localparam int VW = DW * VS;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          exValid = 1'b0, exIsVector = 1'b0;
    logic [AW-1:0] exAddress = '0;
    logic [DW-1:0] exScalarData = '0;
    logic [VW-1:0] exVectorData = '0;
    logic          memValid = 1'b0, memIsVector = 1'b0;
    logic [AW-1:0] memAddress = '0;
    logic [DW-1:0] memScalarData = '0;
    logic [VW-1:0] memVectorData = '0;
    logic          stall = 1'b0, queryIsVector = 1'b0;
    logic [AW-1:0] queryAddress1 = '0, queryAddress2 = '0;
    logic          exReady, memReady, queryPending1, queryPending2;
    logic          writeEnableScalar, writeEnableVector;
    logic [AW-1:0] writeAddress;
    logic [DW-1:0] writeScalarData;
    logic [VW-1:0] writeVectorData;
    logic [2:0]    count;

    writeback_queue dut (
        .clock(clock), .reset(reset),
        .exValid(exValid), .exReady(exReady),
        .exIsVector(exIsVector), .exAddress(exAddress),
        .exScalarData(exScalarData), .exVectorData(exVectorData),
        .memValid(memValid), .memReady(memReady),
        .memIsVector(memIsVector), .memAddress(memAddress),
        .memScalarData(memScalarData), .memVectorData(memVectorData),
        .stall(stall), .queryIsVector(queryIsVector),
        .queryAddress1(queryAddress1), .queryAddress2(queryAddress2),
        .queryPending1(queryPending1), .queryPending2(queryPending2),
        .writeEnableScalar(writeEnableScalar),
        .writeEnableVector(writeEnableVector),
        .writeAddress(writeAddress), .writeScalarData(writeScalarData),
        .writeVectorData(writeVectorData), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit            isv;
        logic [AW-1:0] a;
        logic [DW-1:0] s;
        logic [VW-1:0] v;
    } ent_t;

    ent_t q[$];
    bit   lastEx = 1'b1;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [VW-1:0] o,
                       input logic [VW-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] v;
        for (int i = 0; i < VS; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic rnd_ex();
        exIsVector   = 1'($urandom_range(0, 1));
        exAddress    = AW'($urandom_range(0, 3));
        exScalarData = DW'($urandom);
        exVectorData = rvec();
    endtask

    task automatic rnd_mem();
        memIsVector   = 1'($urandom_range(0, 1));
        memAddress    = AW'($urandom_range(0, 3));
        memScalarData = DW'($urandom);
        memVectorData = rvec();
    endtask

    // One clock: compare all outputs to the model, then advance it.
    task automatic cyc();
        bit   full, gEx, gMem, exF, memF, pop, p1, p2, rst;
        ent_t e;
        #1;
        rst  = reset;
        full = q.size() == 4;
        gMem = memValid && (!exValid || lastEx);
        gEx  = exValid && (!memValid || !lastEx);
        exF  = rst && !full && gEx;
        memF = rst && !full && gMem;
        pop  = rst && q.size() > 0 && !stall;
        p1 = 0;
        p2 = 0;
        if (rst)
            foreach (q[i])
                if (q[i].isv == queryIsVector) begin
                    if (q[i].a == queryAddress1) p1 = 1;
                    if (q[i].a == queryAddress2) p2 = 1;
                end
        chk("exReady", VW'(exReady), VW'(exF));
        chk("memReady", VW'(memReady), VW'(memF));
        chk("count", VW'(count), VW'(q.size()));
        chk("weScalar", VW'(writeEnableScalar), VW'(pop && !q[0].isv));
        chk("weVector", VW'(writeEnableVector), VW'(pop && q[0].isv));
        chk("pending1", VW'(queryPending1), VW'(p1));
        chk("pending2", VW'(queryPending2), VW'(p2));
        if (pop) begin
            chk("wAddr", VW'(writeAddress), VW'(q[0].a));
            if (q[0].isv) chk("wVec", writeVectorData, q[0].v);
            else chk("wScalar", VW'(writeScalarData), VW'(q[0].s));
        end
        if (exF) e = '{exIsVector, exAddress, exScalarData, exVectorData};
        else e = '{memIsVector, memAddress, memScalarData, memVectorData};
        @(posedge clock);
        if (!rst) begin
            q.delete();
            lastEx = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (exF || memF) begin
                q.push_back(e);
                lastEx = exF;
            end
        end
        #1;
    endtask

    initial begin
        exValid  = 1'b1;
        memValid = 1'b1;
        @(posedge clock);
        #1;
        chk("rstExReady", VW'(exReady), '0);
        chk("rstMemReady", VW'(memReady), '0);
        cyc();
        exValid  = 1'b0;
        memValid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rstCount", VW'(count), '0);

        // Single scalar write from execute.
        exValid = 1'b1; exIsVector = 1'b0;
        exAddress = 4'd3; exScalarData = 18'h155;
        cyc();
        exValid = 1'b0;
        #1;
        chk("s1We", VW'(writeEnableScalar), VW'(1));
        chk("s1Addr", VW'(writeAddress), VW'(3));
        chk("s1Data", VW'(writeScalarData), VW'(18'h155));
        cyc();
        chk("s1Count", VW'(count), '0);

        // Tie alternation under stall until full.
        stall = 1'b1;
        exValid = 1'b1;
        memValid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rnd_ex();
            rnd_mem();
            #1;
            chk("rrMem", VW'(memReady), VW'(k % 2 == 0));
            chk("rrEx", VW'(exReady), VW'(k % 2 == 1));
            cyc();
        end
        #1;
        chk("fullCount", VW'(count), VW'(4));
        chk("fullEx", VW'(exReady), '0);
        chk("fullMem", VW'(memReady), '0);
        cyc();

        // Full queue released: pop this cycle, accept next.
        stall = 1'b0;
        memValid = 1'b0;
        #1;
        chk("relEx0", VW'(exReady), '0);
        cyc();
        chk("relEx1", VW'(exReady), VW'(1));
        exValid = 1'b0;
        repeat (5) cyc();

        // Hazard query on a queued vector entry.
        stall = 1'b1;
        exValid = 1'b1; exIsVector = 1'b1; exAddress = 4'd5;
        exVectorData = rvec();
        cyc();
        exValid = 1'b0;
        queryIsVector = 1'b1;
        queryAddress1 = 4'd5;
        queryAddress2 = 4'd5;
        #1;
        chk("hzV1", VW'(queryPending1), VW'(1));
        chk("hzV2", VW'(queryPending2), VW'(1));
        queryIsVector = 1'b0;
        #1;
        chk("hzS1", VW'(queryPending1), '0);
        chk("hzS2", VW'(queryPending2), '0);
        cyc();

        // Reset mid-operation discards queued entries.
        exValid = 1'b1;
        repeat (2) begin
            rnd_ex();
            cyc();
        end
        exValid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midRstWe", VW'(writeEnableScalar | writeEnableVector), '0);
        cyc();
        reset = 1'b1;
        stall = 1'b0;
        exValid = 1'b1; exIsVector = 1'b0;
        exAddress = 4'd9; exScalarData = 18'h2a5;
        #1;
        chk("midRstCount", VW'(count), '0);
        chk("midRstWe2", VW'(writeEnableScalar), '0);
        cyc();
        exValid = 1'b0;
        #1;
        chk("postRstAddr", VW'(writeAddress), VW'(9));
        chk("postRstData", VW'(writeScalarData), VW'(18'h2a5));
        cyc();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            exValid  = $urandom_range(0, 9) < 6;
            memValid = $urandom_range(0, 9) < 6;
            stall    = $urandom_range(0, 9) < 3;
            reset    = $urandom_range(0, 49) != 0;
            rnd_ex();
            rnd_mem();
            queryIsVector = 1'($urandom_range(0, 1));
            queryAddress1 = AW'($urandom_range(0, 3));
            queryAddress2 = AW'($urandom_range(0, 3));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
